// File: rtl/tpe_ctrl_pkg.sv
// tpe_ctrl_pkg: shared state type and constants for the TPE stream controller
package tpe_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;
  localparam int OPA_WIDTH    = 128;
  localparam int RESULT_WIDTH = 20;
  localparam int DEF_W_DEPTH  = 16;
endpackage

// File: rtl/tpe_stream_ctrl_if.sv
// tpe_stream_ctrl_if: job config, weight and operand streams feeding the controller
interface tpe_stream_ctrl_if
  import tpe_ctrl_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CNT_W-1:0]     cfg_len;
  logic                 cfg_load_w;
  logic                 w_valid;
  logic                 w_ready;
  logic [8*N-1:0]       w_data;
  logic                 a_valid;
  logic                 a_ready;
  logic [OPA_WIDTH-1:0] a_data;
  modport master (
    output cfg_valid, cfg_len, cfg_load_w, w_valid, w_data, a_valid, a_data,
    input  cfg_ready, w_ready, a_ready
  );
  modport slave (
    input  cfg_valid, cfg_len, cfg_load_w, w_valid, w_data, a_valid, a_data,
    output cfg_ready, w_ready, a_ready
  );
endinterface

// File: rtl/tpe_valid_skew.sv
// tpe_valid_skew: valid shift register with current and next-cycle all-zero flags
module tpe_valid_skew #(
  parameter int DEPTH = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  output logic [DEPTH-1:0] v,
  output logic             empty,
  output logic             empty_nxt
);
  logic [DEPTH-1:0] v_nxt;
  assign v_nxt     = {v[DEPTH-2:0], push};
  assign empty     = v == '0;
  assign empty_nxt = v_nxt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v <= '0;
    else        v <= v_nxt;
endmodule

// File: rtl/tpe_stream_ctrl.sv
// tpe_stream_ctrl: loads PE weights, streams operand vectors and tracks per-column result valids
module tpe_stream_ctrl
  import tpe_ctrl_pkg::*;
#(
  parameter int N        = 32,
  parameter int W_DEPTH  = DEF_W_DEPTH,
  parameter int PIPE_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tpe_stream_ctrl_if.slave     s,
  output logic [OPA_WIDTH-1:0] tpe_operand_a,
  output logic                 tpe_weight_wen,
  output logic [8*N-1:0]       tpe_weight_din,
  output logic [N-1:0]         col_valid,
  output logic                 busy,
  output logic                 done
);
  localparam int WC_W = $clog2(W_DEPTH + 1);
  localparam int DEPTH = PIPE_LAT + N;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] rem;
  logic [WC_W-1:0]  wcnt;
  logic [DEPTH-1:0] v;
  logic             empty, empty_nxt;
  logic             cfg_fire, w_fire, a_fire, w_last, a_last;
  assign cfg_fire = s.cfg_valid && s.cfg_ready;
  assign w_fire   = s.w_valid && s.w_ready;
  assign a_fire   = s.a_valid && s.a_ready;
  assign w_last   = w_fire && wcnt == WC_W'(W_DEPTH - 1);
  assign a_last   = a_fire && rem == CNT_W'(1);
  assign col_valid = v[PIPE_LAT +: N];
  tpe_valid_skew #(.DEPTH(DEPTH)) u_skew (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (a_fire),
    .v         (v),
    .empty     (empty),
    .empty_nxt (empty_nxt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = !cfg_fire ? IDLE : s.cfg_load_w ? LOAD_W : s.cfg_len == '0 ? DRAIN : STREAM;
      LOAD_W:  state_nxt = !w_last ? LOAD_W : rem == '0 ? DRAIN : STREAM;
      STREAM:  state_nxt = a_last ? DRAIN : STREAM;
      DRAIN:   state_nxt = empty_nxt ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    s.cfg_ready = rst_n && state == IDLE;
    s.w_ready   = state == LOAD_W;
    s.a_ready   = state == STREAM && rem != '0;
    busy        = state != IDLE || !empty;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem            <= '0;
      wcnt           <= '0;
      tpe_operand_a  <= '0;
      tpe_weight_wen <= 1'b0;
      tpe_weight_din <= '0;
      done           <= 1'b0;
    end else begin
      rem            <= cfg_fire ? s.cfg_len : a_fire ? rem - CNT_W'(1) : rem;
      wcnt           <= w_last ? '0 : w_fire ? wcnt + WC_W'(1) : wcnt;
      tpe_operand_a  <= a_fire ? s.a_data : tpe_operand_a;
      tpe_weight_wen <= w_fire;
      tpe_weight_din <= w_fire ? s.w_data : tpe_weight_din;
      done           <= state == DRAIN && empty_nxt;
    end
endmodule

// File: doc/tpe_stream_ctrl.md
# tpe_stream_ctrl

Sequencer for the tensor processing engine array: it loads the 16-entry weight set into all N PE tiles, then streams a job of operand vectors into the vector encoder. It produces per-column result-valid strobes that follow the encoder/tile pipeline skew, and signals job completion. It sits between the job/operand source and the engine top, and owns the engine's operand_a, weight_wen and weight_din inputs.

## Interface
- N, 32, number of PE tiles (result columns)
- W_DEPTH, 16, weight writes per tile per weight load (one per 8-bit operand lane)
- PIPE_LAT, 2, cycles from engine operand_a input to column 0 result
- CNT_W, 16, width of job length field
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  job request
- cfg_ready  out  1  high only in IDLE
- cfg_len  in  CNT_W  number of operand vectors in job (0 allowed)
- cfg_load_w  in  1  1 = load W_DEPTH weight words before streaming
- w_valid  in  1  weight word valid
- w_ready  out  1  high only in LOAD_W
- w_data  in  8*N  one 8-bit weight per tile
- a_valid  in  1  operand vector valid
- a_ready  out  1  high in STREAM while beats remain
- a_data  in  128  16 x 8-bit operand lanes
- tpe_operand_a  out  128  to engine
- tpe_weight_wen  out  1  to engine
- tpe_weight_din  out  8*N  to engine
- col_valid  out  N  bit i: engine result column i valid this cycle
- busy  out  1  state != IDLE or skew pipeline non-empty
- done  out  1  one-cycle job-complete pulse

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN.
- IDLE: cfg_ready=1. On cfg_valid, latch cfg_len into remaining counter and go to LOAD_W if cfg_load_w, else STREAM (DRAIN if cfg_len==0).
- LOAD_W: w_ready=1. Each w_valid&w_ready beat registers w_data to tpe_weight_din with tpe_weight_wen=1 in the next cycle. The beat counter counts to W_DEPTH; on the W_DEPTH-th beat go to STREAM (DRAIN if cfg_len==0).
- STREAM: a_ready = (remaining != 0). Each accepted beat registers a_data to tpe_operand_a, pushes 1 into the skew pipeline and decrements remaining. Cycles without a beat push 0 and hold tpe_operand_a. On the last beat go to DRAIN.
- DRAIN: wait until the skew pipeline is all-zero, then pulse done and return to IDLE.
- Weights are never written while any operand is in flight: LOAD_W is entered only from IDLE, and IDLE is reached only after DRAIN empties.
- The skew pipeline is a PIPE_LAT+N bit shift register v. v[0] is the bit pushed in the previous cycle. col_valid[i] = v[PIPE_LAT+i].
- Reset (any time, including mid-job): state IDLE; counters, v, tpe_operand_a and tpe_weight_din cleared to 0; tpe_weight_wen, col_valid, done and busy all 0. No partial job resumes.

## Timing
- Operand beat accepted in cycle t: tpe_operand_a updates at t+1, and col_valid[i] is high in cycle t+1+PIPE_LAT+i.
- Weight beat accepted in cycle t: tpe_weight_wen/tpe_weight_din are active in cycle t+1.
- done is high for exactly one cycle: the cycle after the cycle in which v becomes all-zero in DRAIN. The state is IDLE in that cycle, so cfg_ready=1 and a new job may be accepted in the same cycle.
- cfg_len==0 without load: DRAIN is entered at t+1 and done fires at t+2.
- The counter for remaining uses CNT_W bits and does not wrap: a_ready drops at 0.
- Back-to-back beats sustain 1 vector/cycle. Bubbles in a_valid propagate as gaps in col_valid.

## Structure
- Package tpe_ctrl_pkg holds the state enum, OPA_WIDTH=128, RESULT_WIDTH=20 and the default W_DEPTH.
- One sub-module, tpe_valid_skew: a parameterised shift register (depth PIPE_LAT+N) with an all-zero flag. It is reused by downstream result collectors.

## Test plan
- Reset, then cfg_len=3, load_w=1, 16 weight beats, then 3 contiguous operand beats accepted at cycles 20,21,22 (N=32, PIPE_LAT=2) -> 16 wen pulses; col_valid[0] high at 23..25; col_valid[31] high at 54..56; done at 57.
- a_valid toggling 1,0,1 during STREAM (cfg_len=2) -> col_valid[0] pattern 1,0,1; tpe_operand_a held through the bubble.
- cfg_len=0, load_w=0 -> done two cycles after cfg accept; no col_valid; no wen.
- w_valid gaps during LOAD_W -> exactly 16 wen pulses; a_ready stays 0 until the 16th beat.
- rst_n asserted mid-STREAM -> all outputs 0 immediately; cfg_ready=1 after release; no done pulse.
- done cycle coincides with a new cfg_valid -> new job accepted in that cycle with no lost cycle.
